// File: rtl/i4001_bus_if.sv
// Bus-side stage of the i4001 emulation: tracks the 4004 eight-phase cycle, fetches from ROM storage,
// drives OPR/OPA when selected. The SRC/WRR/RDR I/O port is built only when I4001_IO_PORT_EN is defined.
module i4001_bus_if #(
  parameter logic [3:0] CHIP_ID = 4'h0,
  parameter logic [3:0] IO_MASK = 4'hF
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SYNC,
  input  logic       CM_ROM,
  input  logic [3:0] D_IN,
  output logic [3:0] D_OUT,
  output logic       D_OE,
  output logic [7:0] rom_addr,
  output logic       rom_rd,
  input  logic [7:0] rom_data,
  input  logic [3:0] io_in,
  output logic [3:0] io_out,
  output logic [2:0] phase,
  output logic       active
);

  typedef enum logic [3:0] {
    S_IDLE, S_A1, S_A2, S_A3, S_M1, S_M2, S_X1, S_X2, S_X3
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  rom_addr_q, rom_addr_d;
  logic        sel_q, sel_d;
  logic [7:0]  rom_byte_q, rom_byte_d;
  logic        rdr_en;
  logic [3:0]  rdr_data;

  // SYNC wins from any state, which doubles as the resync path.
  always_comb begin
    state_d = state_q;
    if (SYNC) begin
      state_d = S_A1;
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_A1:    state_d = S_A2;
        S_A2:    state_d = S_A3;
        S_A3:    state_d = S_M1;
        S_M1:    state_d = S_M2;
        S_M2:    state_d = S_X1;
        S_X1:    state_d = S_X2;
        S_X2:    state_d = S_X3;
        S_X3:    state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    rom_addr_d = rom_addr_q;
    sel_d      = sel_q;
    rom_byte_d = rom_byte_q;
    rom_rd     = 1'b0;
    D_OE       = 1'b0;
    D_OUT      = 4'h0;
    unique case (state_q)
      S_A1: rom_addr_d[3:0] = D_IN;
      S_A2: rom_addr_d[7:4] = D_IN;
      S_A3: begin
        sel_d  = (D_IN == CHIP_ID) && CM_ROM;
        rom_rd = sel_d;
      end
      S_M1: begin
        // ROM storage answers one cycle after the A3 strobe, so OPR is passed straight through.
        rom_byte_d = rom_data;
        if (sel_q) begin
          D_OE  = 1'b1;
          D_OUT = rom_data[7:4];
        end
      end
      S_M2: begin
        if (sel_q) begin
          D_OE  = 1'b1;
          D_OUT = rom_byte_q[3:0];
        end
      end
      S_X2: begin
        if (rdr_en) begin
          D_OE  = 1'b1;
          D_OUT = rdr_data;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    phase = 3'd0;
    unique case (state_q)
      S_A1:    phase = 3'd0;
      S_A2:    phase = 3'd1;
      S_A3:    phase = 3'd2;
      S_M1:    phase = 3'd3;
      S_M2:    phase = 3'd4;
      S_X1:    phase = 3'd5;
      S_X2:    phase = 3'd6;
      S_X3:    phase = 3'd7;
      default: phase = 3'd0;
    endcase
  end

  assign active   = (state_q != S_IDLE);
  assign rom_addr = rom_addr_q;

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      rom_addr_q <= 8'h00;
      sel_q      <= 1'b0;
      rom_byte_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      sel_q      <= sel_d;
      rom_byte_q <= rom_byte_d;
    end
  end

`ifdef I4001_IO_PORT_EN
  logic       io_cmd_q, io_cmd_d;
  logic [3:0] opa_q, opa_d;
  logic       src_hit_q, src_hit_d;
  logic [3:0] io_out_q, io_out_d;

  // io_cmd/opa describe this cycle's instruction; src_hit survives until the next SRC.
  always_comb begin
    io_cmd_d  = io_cmd_q;
    opa_d     = opa_q;
    src_hit_d = src_hit_q;
    io_out_d  = io_out_q;
    rdr_en    = 1'b0;
    if (state_q == S_M2) begin
      io_cmd_d = CM_ROM;
      opa_d    = sel_q ? rom_byte_q[3:0] : D_IN;
    end
    if (state_q == S_X2) begin
      if (CM_ROM && !io_cmd_q) begin
        src_hit_d = (D_IN == CHIP_ID);
      end
      if (io_cmd_q && src_hit_q && (opa_q == 4'h2)) begin
        io_out_d = (D_IN & IO_MASK) | (io_out_q & ~IO_MASK);
      end
      if (io_cmd_q && src_hit_q && (opa_q == 4'hA)) begin
        rdr_en = 1'b1;
      end
    end
  end

  assign rdr_data = io_in & ~IO_MASK;
  assign io_out   = io_out_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      io_cmd_q  <= 1'b0;
      opa_q     <= 4'h0;
      src_hit_q <= 1'b0;
      io_out_q  <= 4'h0;
    end else begin
      io_cmd_q  <= io_cmd_d;
      opa_q     <= opa_d;
      src_hit_q <= src_hit_d;
      io_out_q  <= io_out_d;
    end
  end
`else
  logic unused_io_in;
  assign unused_io_in = ^io_in;
  assign rdr_en       = 1'b0;
  assign rdr_data     = 4'h0;
  assign io_out       = 4'h0;
`endif

endmodule

// File: tb/tb_i4001_bus_if.sv
// Directed bench for i4001_bus_if: fetch hit/miss, SRC/WRR/RDR, resync, free-run to IDLE, mid-cycle reset.
module tb_i4001_bus_if;

  localparam bit IO_EN =
`ifdef I4001_IO_PORT_EN
    1'b1;
`else
    1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       SYNC = 1'b0;
  logic       CM_ROM = 1'b0;
  logic [3:0] D_IN = 4'h0;
  logic [3:0] D_OUT;
  logic       D_OE;
  logic [7:0] rom_addr;
  logic       rom_rd;
  logic [7:0] rom_data = 8'h00;
  logic [3:0] io_in = 4'hC;
  logic [3:0] io_out;
  logic [2:0] phase;
  logic       active;

  logic [7:0] mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] obs_oe, obs_rd, obs_phok, obs_act;
  logic [3:0] obs_out [8];
  logic [7:0] obs_addr;

  i4001_bus_if #(.CHIP_ID(4'h0), .IO_MASK(4'b0011)) dut (
    .CLK(CLK), .RESET(RESET), .SYNC(SYNC), .CM_ROM(CM_ROM), .D_IN(D_IN),
    .D_OUT(D_OUT), .D_OE(D_OE), .rom_addr(rom_addr), .rom_rd(rom_rd),
    .rom_data(rom_data), .io_in(io_in), .io_out(io_out), .phase(phase),
    .active(active)
  );

  always #5 CLK = ~CLK;

  // Synchronous ROM, one-cycle latency; output is zero on cycles without a read.
  always @(posedge CLK) rom_data <= rom_rd ? mem[rom_addr] : 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive inputs just after the rising edge, return at the falling edge for sampling.
  task automatic tick(input logic s, input logic c, input logic [3:0] d);
    @(posedge CLK);
    #1;
    SYNC   = s;
    CM_ROM = c;
    D_IN   = d;
    @(negedge CLK);
  endtask

  // One SYNC cycle followed by A1..X3, X3 without SYNC so the chip falls back to IDLE.
  task automatic fetch(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3,
                       input logic cm_a3, input logic cm_m2, input logic [3:0] m2_din,
                       input logic cm_x2, input logic [3:0] x2_din);
    logic       c;
    logic [3:0] d;
    tick(1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 8; i++) begin
      c = 1'b0;
      d = 4'h0;
      case (i)
        0: d = a1;
        1: d = a2;
        2: begin d = a3; c = cm_a3; end
        4: begin d = m2_din; c = cm_m2; end
        6: begin d = x2_din; c = cm_x2; end
        default: ;
      endcase
      tick(1'b0, c, d);
      obs_oe[i]   = D_OE;
      obs_rd[i]   = rom_rd;
      obs_out[i]  = D_OUT;
      obs_phok[i] = (phase == 3'(i));
      obs_act[i]  = active;
      if (i == 2) obs_addr = rom_addr;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h35] = 8'hE2;
    mem[8'hA7] = 8'h5C;

    // Reset state
    tick(1'b0, 1'b0, 4'h0);
    tick(1'b0, 1'b0, 4'h0);
    check("rst_phase",  32'(phase),    32'h0);
    check("rst_active", 32'(active),   32'h0);
    check("rst_oe",     32'(D_OE),     32'h0);
    check("rst_dout",   32'(D_OUT),    32'h0);
    check("rst_rd",     32'(rom_rd),   32'h0);
    check("rst_addr",   32'(rom_addr), 32'h0);
    check("rst_io_out", 32'(io_out),   32'h0);
    RESET = 1'b0;

    // Fetch hit at 0x35 -> E2
    fetch(4'h5, 4'h3, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    check("hit_addr",  32'(obs_addr),   32'h35);
    check("hit_rd",    32'(obs_rd),     32'h04);
    check("hit_oe",    32'(obs_oe),     32'h18);
    check("hit_opr",   32'(obs_out[3]), 32'hE);
    check("hit_opa",   32'(obs_out[4]), 32'h2);
    check("hit_phase", 32'(obs_phok),   32'hFF);
    check("hit_act",   32'(obs_act),    32'hFF);
    tick(1'b0, 1'b0, 4'h0);
    check("x3_idle_act",   32'(active), 32'h0);
    check("x3_idle_phase", 32'(phase),  32'h0);

    // Second hit at 0xA7 -> 5C
    fetch(4'h7, 4'hA, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    check("hit2_addr", 32'(obs_addr),   32'hA7);
    check("hit2_opr",  32'(obs_out[3]), 32'h5);
    check("hit2_opa",  32'(obs_out[4]), 32'hC);

    // Miss: wrong chip number, then CM_ROM low
    fetch(4'h5, 4'h3, 4'h1, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    check("miss_id_rd", 32'(obs_rd), 32'h0);
    check("miss_id_oe", 32'(obs_oe), 32'h0);
    fetch(4'h5, 4'h3, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    check("miss_cm_rd", 32'(obs_rd), 32'h0);
    check("miss_cm_oe", 32'(obs_oe), 32'h0);

    // SRC hit (io_cmd=0, CM_ROM=1 in X2, D_IN=CHIP_ID), then WRR F through mask 0011
    fetch(4'h0, 4'h0, 4'h1, 1'b1, 1'b0, 4'h0, 1'b1, 4'h0);
    check("src_oe", 32'(obs_oe), 32'h0);
    fetch(4'h0, 4'h0, 4'h1, 1'b1, 1'b1, 4'h2, 1'b0, 4'hF);
    check("wrr_io_out", 32'(io_out), IO_EN ? 32'h3 : 32'h0);
    check("wrr_oe",     32'(obs_oe), 32'h0);

    // RDR: io_in=C, input bits are ~0011 -> C
    fetch(4'h0, 4'h0, 4'h1, 1'b1, 1'b1, 4'hA, 1'b0, 4'h0);
    check("rdr_oe",   32'(obs_oe),     IO_EN ? 32'h40 : 32'h0);
    check("rdr_dout", 32'(obs_out[6]), IO_EN ? 32'hC : 32'h0);

    // SRC miss clears src_hit, so the following WRR of 0 must not touch io_out
    fetch(4'h0, 4'h0, 4'h1, 1'b1, 1'b0, 4'h0, 1'b1, 4'h5);
    fetch(4'h0, 4'h0, 4'h1, 1'b1, 1'b1, 4'h2, 1'b0, 4'h0);
    check("src_miss_io_out", 32'(io_out), IO_EN ? 32'h3 : 32'h0);

    // Resync: SYNC pulsed during M1 of a selected fetch
    tick(1'b1, 1'b0, 4'h0);
    tick(1'b0, 1'b0, 4'h5);
    tick(1'b0, 1'b0, 4'h3);
    tick(1'b0, 1'b1, 4'h0);
    tick(1'b1, 1'b0, 4'h0);
    check("resync_m1_oe", 32'(D_OE), 32'h1);
    tick(1'b0, 1'b0, 4'h0);
    check("resync_phase",  32'(phase),  32'h0);
    check("resync_active", 32'(active), 32'h1);
    check("resync_oe",     32'(D_OE),   32'h0);
    for (int i = 0; i < 7; i++) tick(1'b0, 1'b0, 4'h0);
    check("freerun_x3_phase", 32'(phase), 32'h7);
    tick(1'b0, 1'b0, 4'h0);
    check("freerun_idle_act", 32'(active), 32'h0);
    tick(1'b0, 1'b0, 4'h0);
    check("idle_hold_act",   32'(active), 32'h0);
    check("idle_hold_phase", 32'(phase),  32'h0);
    check("resync_io_out",   32'(io_out), IO_EN ? 32'h3 : 32'h0);

    // Reset during M2 of a selected fetch
    tick(1'b1, 1'b0, 4'h0);
    tick(1'b0, 1'b0, 4'h5);
    tick(1'b0, 1'b0, 4'h3);
    tick(1'b0, 1'b1, 4'h0);
    tick(1'b0, 1'b0, 4'h0);
    tick(1'b0, 1'b0, 4'h0);
    check("pre_rst_m2_oe", 32'(D_OE), 32'h1);
    RESET = 1'b1;
    tick(1'b0, 1'b0, 4'h0);
    check("midrst_oe",     32'(D_OE),   32'h0);
    check("midrst_io_out", 32'(io_out), 32'h0);
    check("midrst_phase",  32'(phase),  32'h0);
    check("midrst_active", 32'(active), 32'h0);
    RESET = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i4001_bus_if.md
Name: i4001_bus_if

Overview:
- Bus-side stage of the i4001 emulation in run and debug modes. It sits directly downstream of the ROM storage block and upstream of the CPU-side 4-bit data bus.
- Tracks the 4004 eight-phase instruction cycle, assembles the 8-bit address, and issues a read to ROM storage.
- When chip-selected, drives the returned byte onto the bus as OPR then OPA.
- Implements the 4001 I/O port: SRC latch, WRR write, RDR read.

Parameters:
- CHIP_ID, 4'h0: chip number matched in A3 and during SRC.
- IO_MASK, 4'hF: per-bit I/O direction; 1 = output, 0 = input.

Ports:
- CLK  in  1  system clock; one bus phase per cycle.
- RESET  in  1  synchronous, active-high reset.
- SYNC  in  1  high in X3 marks the next cycle as A1.
- CM_ROM  in  1  ROM command line from the CPU.
- D_IN  in  4  data bus as seen by this chip.
- D_OUT  out  4  value this chip drives onto the bus.
- D_OE  out  1  bus drive enable.
- rom_addr  out  8  read address to ROM storage.
- rom_rd  out  1  one-cycle read strobe.
- rom_data  in  8  ROM byte, valid the cycle after rom_rd.
- io_in  in  4  port input pins.
- io_out  out  4  port output latch.
- phase  out  3  current phase (A1=0 … X3=7) for the debug 7-seg.
- active  out  1  1 when not IDLE.

Behaviour:
- Reset: state IDLE; phase=0; active=0; D_OE=0; D_OUT=0; rom_rd=0; rom_addr=0; io_out=0; src_hit=0; sel=0. Reset mid-cycle aborts the cycle and drops D_OE the next cycle.
- States: IDLE, A1, A2, A3, M1, M2, X1, X2, X3.
- Transitions:
  - SYNC=1 in any state → next state A1. This is also the resync path.
  - Each phase otherwise advances to the next phase.
  - X3 with SYNC=0 → IDLE.
  - IDLE with SYNC=0 stays in IDLE.
- A1: rom_addr[3:0] <= D_IN.
- A2: rom_addr[7:4] <= D_IN.
- A3:
  - sel <= (D_IN==CHIP_ID) & CM_ROM.
  - rom_rd=1 for this cycle only if the next-state sel is 1; otherwise rom_rd=0.
- M1: byte <= rom_data. If sel: D_OE=1, D_OUT=rom_data[7:4] (OPR), combinational from rom_data.
- M2:
  - If sel: D_OE=1, D_OUT=byte[3:0] (OPA).
  - io_cmd <= CM_ROM.
  - opa <= sel ? byte[3:0] : D_IN.
- X2:
  - If CM_ROM=1 and io_cmd=0 (SRC): src_hit <= (D_IN==CHIP_ID).
  - If io_cmd=1 and src_hit=1 and opa==4'h2 (WRR): io_out <= (D_IN & IO_MASK) | (io_out & ~IO_MASK).
  - If io_cmd=1 and src_hit=1 and opa==4'hA (RDR): D_OE=1, D_OUT=io_in & ~IO_MASK.
- D_OE is 0 in every other phase and condition.
- src_hit persists across cycles until the next SRC or reset.
- rom_addr holds its last value outside A1/A2.
- Latency: A3 strobe → data consumed in M1, a fixed 1 cycle. ROM storage must be synchronous-read with exactly 1-cycle latency.
- SYNC asserted mid-cycle, e.g. in M1: D_OE drops next cycle and no WRR side effect occurs.

Optional Feature:
- Macro: I4001_IO_PORT_EN.
- Defined: SRC/WRR/RDR logic as above.
- Undefined: src_hit and io_cmd logic removed; io_out tied to 0; X2 never drives the bus. ROM fetch behaviour is unchanged.

Test Plan:
- Fetch hit: CHIP_ID=0, rom_data=8'hE2 @ addr 8'h35. Drive SYNC, then A1=5, A2=3, A3=0 with CM_ROM=1 → rom_addr=8'h35 and rom_rd=1 in A3; M1 D_OE=1, D_OUT=E; M2 D_OUT=2; other phases D_OE=0.
- Fetch miss: same sequence with A3 D_IN=4'h1 → rom_rd=0 and D_OE=0 for the entire cycle.
- WRR (macro on, IO_MASK=4'b0011): SRC cycle with X2 D_IN=0 and CM_ROM=1, then a cycle with opa=2, CM_ROM=1 in M2, X2 D_IN=4'hF → io_out=4'h3.
- RDR: after SRC hit, opa=A, io_in=4'hC → X2 D_OE=1, D_OUT=4'hC. With the macro off, D_OE=0 and io_out stays 0.
- Resync/free-run: SYNC pulses at M1 → next cycle phase=0 (A1) and D_OE=0. X3 without SYNC → active=0 and IDLE held.
- Reset mid-cycle: RESET=1 during M2 of a selected fetch → next cycle D_OE=0, io_out=0, phase=0, active=0.
